oram_linear_scan: RTL and testbench

//  Parametrised linear-scan (trivial) ORAM controller; successor to the single-block oram_module front end.

---
 rtl/oram_linear_scan.sv | 127 ++++++++++++
 tb/tb_oram_linear_scan.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/oram_linear_scan.sv
`default_nettype none
// ============================================================================
// Module  : oram_linear_scan
// Brief   : Linear-scan ORAM controller. Each request reads and rewrites every
//           block 0..N-1 of a 1-cycle-latency single-port RAM in fixed order.
// Revision: 1.0
// ============================================================================
module oram_linear_scan #(
  parameter int ADDR_W      = 4,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_dummy,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [8*BLOCK_BYTES-1:0] req_wdata,
  output logic                     resp_valid,
  output logic [8*BLOCK_BYTES-1:0] resp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [8*BLOCK_BYTES-1:0] mem_wdata,
  input  logic [8*BLOCK_BYTES-1:0] mem_rdata
);

  localparam int                DATA_W   = 8 * BLOCK_BYTES;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                write_q;
  logic                dummy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                w_hit;

  // A dummy pass never matches its target, so it rewrites every block as read.
  assign w_hit = (idx_q == addr_q) && !dummy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      dummy_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            dummy_q <= req_dummy;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= '0;
            if (req_dummy) begin
              rdata_q <= '0;
            end
            state_q <= RD;
          end
        end
        RD: begin
          state_q <= WR;
        end
        WR: begin
          if (w_hit) begin
            rdata_q <= mem_rdata;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= RD;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;

  // Address/enable pattern depends only on state and idx, never on the request.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD: begin
        mem_en   = 1'b1;
        mem_addr = idx_q;
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = (w_hit && write_q) ? wdata_q : mem_rdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oram_linear_scan.sv
`default_nettype none
// Bench for oram_linear_scan: directed cases plus random ops against an
// array-level reference of the block memory contents.
module tb_oram_linear_scan;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_dummy;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          preload;
  logic [DW-1:0] mem     [0:N-1];
  logic [DW-1:0] ref_mem [0:N-1];

  int ncmp  = 0;
  int nfail = 0;

  oram_linear_scan #(.ADDR_W(AW), .BLOCK_BYTES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_dummy  (req_dummy),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // External block RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= DW'(8'h10 + i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_mem();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = mem[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_ref();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = ref_mem[i];
    return v;
  endfunction

  function automatic logic [21:0] out_vec();
    return {req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  localparam logic [21:0] RESET_OUTS = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00};

  // One full request: checks latency, access trace, response data and memory.
  task automatic do_op(input string tag, input bit w, input bit d,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_rd;
    logic [31:0]   tr, extr;
    logic [DW-1:0] got;
    int            vk, n;
    exp_rd = d ? '0 : ref_mem[a];
    if (w && !d) ref_mem[a] = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = w; req_dummy = d; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    vk = 0; tr = '0; got = '0; extr = '0;
    for (int k = 1; k <= 8; k++)
      extr[(k-1)*4 +: 4] = {1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, AW'((k - 1) / 2)};
    for (int k = 1; k <= 24; k++) begin
      if (k <= 8) tr[(k-1)*4 +: 4] = {mem_en, mem_we, mem_addr};
      if (resp_valid) begin
        vk  = k;
        got = resp_rdata;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(vk), 64'(2 * N + 1));
    chk({tag, "_trace"}, 64'(tr), 64'(extr));
    chk({tag, "_rdata"}, 64'(got), 64'(exp_rd));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({resp_valid, req_ready, resp_rdata}), 64'({1'b0, 1'b1, exp_rd}));
    chk({tag, "_mem"}, 64'(pack_mem()), 64'(pack_ref()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] mask;
    bit          bad;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_dummy = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = DW'(8'h10 + i);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(out_vec()), 64'(RESET_OUTS));
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);

    do_op("t1_write2", 1'b1, 1'b0, 2'd2, 8'hA5);
    do_op("t2_read2",  1'b0, 1'b0, 2'd2, 8'h00);
    do_op("t3_read0",  1'b0, 1'b0, 2'd0, 8'h00);
    do_op("t3_write3", 1'b1, 1'b0, 2'd3, 8'h13);
    do_op("t3_dummy",  1'b1, 1'b1, 2'd1, 8'h77);

    // Held request: accepts only at n = 0, 10, 20.
    req_valid = 1'b1; req_write = 1'b0; req_dummy = 1'b0; req_addr = 2'd1;
    mask = '0;
    for (int n = 0; n <= 20; n++) begin
      mask[n] = req_ready;
      if (n == 20) req_valid = 1'b0;
      else @(negedge clk);
    end
    chk("t4_ready_pattern", 64'(mask), 64'(21'h100401));
    chk("t4_rdata", 64'(resp_rdata), 64'(ref_mem[1]));
    @(negedge clk);

    // Reset during WR of idx 1.
    req_valid = 1'b1; req_write = 1'b1; req_dummy = 1'b0; req_addr = 2'd3; req_wdata = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_in_wr1", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 2'd1}));
    rst = 1'b1;
    #1;
    chk("t5_async_reset", 64'(out_vec()), 64'(RESET_OUTS));
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (resp_valid || !req_ready) bad = 1'b1;
      @(negedge clk);
    end
    chk("t5_no_resp", 64'(bad), 64'(0));
    chk("t5_mem", 64'(pack_mem()), 64'(pack_ref()));
    do_op("t5_read3", 1'b0, 1'b0, 2'd3, 8'h00);

    // Reset and request together: the request must be dropped.
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (resp_valid || !req_ready || mem_en) bad = 1'b1;
      @(negedge clk);
    end
    chk("rst_and_valid_ignored", 64'(bad), 64'(0));

    do_op("t6_write0", 1'b1, 1'b0, 2'd0, 8'h00);
    do_op("t6_read0",  1'b0, 1'b0, 2'd0, 8'h00);
    do_op("t6_write3", 1'b1, 1'b0, 2'd3, 8'h00);
    do_op("t6_read3",  1'b0, 1'b0, 2'd3, 8'h00);

    for (int i = 0; i < 12; i++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      do_op($sformatf("rnd%0d", i), op == 1, op == 2,
            AW'($urandom_range(0, N - 1)), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
